mtimer_bank: RTL

//  Memory-mapped machine timer: one free-running prescaled counter (mtime) shared by CHANNELS compare channels.

---
 rtl/mtimer_bank.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mtimer_bank.sv
// mtimer_bank: memory-mapped machine timer. One prescaled free-running mtime
// counter is shared by CHANNELS compare channels. Each channel can run one-shot
// or periodic (auto-reload) and has a sticky pending bit that drives an irq line.
//
// Ports:
//   clk24          core clock, all logic on posedge
//   reset_n        synchronous active-low reset
//   memory_address byte address from the core
//   write_value    write data, already lane-shifted
//   write_sections byte-lane write enables (0 = no write)
//   read_value     registered read data (1-cycle latency)
//   read_hit       registered: previous-cycle address was inside the window
//   irq            per-channel pending bits
//   irq_any        OR of irq (feeds mip_mtip)
module mtimer_bank #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned COUNTER_WIDTH  = 64,
    parameter int unsigned PRESCALE_WIDTH = 8,
    parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000
) (
    input  logic                clk24,
    input  logic                reset_n,
    input  logic [31:0]         memory_address,
    input  logic [31:0]         write_value,
    input  logic [3:0]          write_sections,
    output logic [31:0]         read_value,
    output logic                read_hit,
    output logic [CHANNELS-1:0] irq,
    output logic                irq_any
);

    localparam int unsigned CW           = COUNTER_WIDTH;
    localparam int unsigned PW           = PRESCALE_WIDTH;
    localparam int unsigned WINDOW_WORDS = 8 + 4 * CHANNELS;
    localparam int unsigned WINDOW_BYTES = 4 * WINDOW_WORDS;

    // Architectural state
    logic [CW-1:0]       mtime;
    logic [PW-1:0]       presc_cnt;
    logic [PW-1:0]       prescale;
    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] mode;
    logic [CHANNELS-1:0] pending;
    logic [CW-1:0]       cmp    [CHANNELS];
    logic [CW-1:0]       period [CHANNELS];

    // Next-state values
    logic [CW-1:0]       mtime_nxt;
    logic [PW-1:0]       presc_cnt_nxt;
    logic [PW-1:0]       prescale_nxt;
    logic [CHANNELS-1:0] enable_nxt;
    logic [CHANNELS-1:0] mode_nxt;
    logic [CHANNELS-1:0] pending_nxt;
    logic [CW-1:0]       cmp_nxt    [CHANNELS];
    logic [CW-1:0]       period_nxt [CHANNELS];

    logic [31:0]         addr_off;
    logic [29:0]         word_off;
    logic                in_window;
    logic                wr;
    logic                tick;
    logic [CHANNELS-1:0] match;
    logic [31:0]         rd_data;

    // Byte-lane merge of write data into an old 32-bit word
    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] ws);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = ws[b] ? wd[8*b +: 8] : old[8*b +: 8];
        end
        return r;
    endfunction

    // Replace the lo or hi word of a 64-bit value with byte-merged write data
    function automatic logic [63:0] put_word(input logic [63:0] old, input logic sel_hi,
                                             input logic [31:0] wd, input logic [3:0] ws);
        logic [63:0] r;
        r = old;
        if (sel_hi) r[63:32] = merge32(old[63:32], wd, ws);
        else        r[31:0]  = merge32(old[31:0], wd, ws);
        return r;
    endfunction

    function automatic logic [31:0] word_of(input logic [63:0] v, input logic sel_hi);
        return sel_hi ? v[63:32] : v[31:0];
    endfunction

    // Address decode; subtracting the base first makes below-base addresses wrap out of range
    assign addr_off  = memory_address - BASE_ADDRESS;
    assign word_off  = addr_off[31:2];
    assign in_window = addr_off < 32'(WINDOW_BYTES);
    assign wr        = in_window && (write_sections != 4'b0000);

    assign tick = (presc_cnt == prescale);

    // Compare on registered values, no wrap correction
    always_comb begin
        match = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            match[i] = enable[i] && (mtime >= cmp[i]);
        end
    end

    // Next-state: hardware updates first, software byte writes layered on top so they win
    always_comb begin
        mtime_nxt     = mtime;
        presc_cnt_nxt = presc_cnt;
        prescale_nxt  = prescale;
        enable_nxt    = enable;
        mode_nxt      = mode;
        pending_nxt   = pending;
        for (int i = 0; i < CHANNELS; i++) begin
            cmp_nxt[i]    = cmp[i];
            period_nxt[i] = period[i];
        end

        if (wr && word_off == 30'd0) begin
            mtime_nxt = CW'(put_word(64'(mtime), 1'b0, write_value, write_sections));
        end else if (wr && word_off == 30'd1) begin
            mtime_nxt = CW'(put_word(64'(mtime), 1'b1, write_value, write_sections));
        end else if (tick) begin
            mtime_nxt = mtime + CW'(1);
        end

        if (wr && word_off == 30'd2) begin
            prescale_nxt  = PW'(merge32(32'(prescale), write_value, write_sections));
            presc_cnt_nxt = '0;
        end else if (tick) begin
            presc_cnt_nxt = '0;
        end else begin
            presc_cnt_nxt = presc_cnt + PW'(1);
        end

        // W1C, but a same-edge match keeps the bit set
        if (wr && word_off == 30'd3) begin
            pending_nxt = pending & ~CHANNELS'(merge32(32'd0, write_value, write_sections));
        end
        pending_nxt = pending_nxt | match;

        // One-shot channels disarm on match
        enable_nxt = enable & ~(match & ~mode);
        if (wr && word_off == 30'd4) begin
            enable_nxt = CHANNELS'(merge32(32'(enable_nxt), write_value, write_sections));
        end

        if (wr && word_off == 30'd5) begin
            mode_nxt = CHANNELS'(merge32(32'(mode), write_value, write_sections));
        end

        for (int i = 0; i < CHANNELS; i++) begin
            if (match[i] && mode[i]) begin
                cmp_nxt[i] = cmp[i] + period[i];
            end
            if (wr && word_off == 30'(8 + 4 * i)) begin
                cmp_nxt[i] = CW'(put_word(64'(cmp_nxt[i]), 1'b0, write_value, write_sections));
            end else if (wr && word_off == 30'(9 + 4 * i)) begin
                cmp_nxt[i] = CW'(put_word(64'(cmp_nxt[i]), 1'b1, write_value, write_sections));
            end
            if (wr && word_off == 30'(10 + 4 * i)) begin
                period_nxt[i] = CW'(put_word(64'(period[i]), 1'b0, write_value, write_sections));
            end else if (wr && word_off == 30'(11 + 4 * i)) begin
                period_nxt[i] = CW'(put_word(64'(period[i]), 1'b1, write_value, write_sections));
            end
        end
    end

    // Read mux from the current address; unmapped offsets read 0
    always_comb begin
        rd_data = '0;
        case (word_off)
            30'd0:   rd_data = word_of(64'(mtime), 1'b0);
            30'd1:   rd_data = word_of(64'(mtime), 1'b1);
            30'd2:   rd_data = 32'(prescale);
            30'd3:   rd_data = 32'(pending);
            30'd4:   rd_data = 32'(enable);
            30'd5:   rd_data = 32'(mode);
            default: rd_data = '0;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            if (word_off == 30'(8 + 4 * i))  rd_data = word_of(64'(cmp[i]), 1'b0);
            if (word_off == 30'(9 + 4 * i))  rd_data = word_of(64'(cmp[i]), 1'b1);
            if (word_off == 30'(10 + 4 * i)) rd_data = word_of(64'(period[i]), 1'b0);
            if (word_off == 30'(11 + 4 * i)) rd_data = word_of(64'(period[i]), 1'b1);
        end
    end

    // State registers; reset discards any write or read presented on the same edge
    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            mtime      <= '0;
            presc_cnt  <= '0;
            prescale   <= '0;
            enable     <= '0;
            mode       <= '0;
            pending    <= '0;
            read_value <= '0;
            read_hit   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cmp[i]    <= '1;
                period[i] <= '0;
            end
        end else begin
            mtime      <= mtime_nxt;
            presc_cnt  <= presc_cnt_nxt;
            prescale   <= prescale_nxt;
            enable     <= enable_nxt;
            mode       <= mode_nxt;
            pending    <= pending_nxt;
            read_value <= in_window ? rd_data : 32'd0;
            read_hit   <= in_window;
            for (int i = 0; i < CHANNELS; i++) begin
                cmp[i]    <= cmp_nxt[i];
                period[i] <= period_nxt[i];
            end
        end
    end

    assign irq     = pending;
    assign irq_any = |pending;

endmodule
